// File: rtl/sprite_animator_pkg.sv
// Shared definitions for the sprite animator: direction and FSM encodings,
// default sprite-sheet geometry, and counter widths.
// Ports: none (package only).
package sprite_animator_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_IDLE = 2'd1,
    ST_WALK = 2'd2
  } state_e;

  // Default sprite-sheet geometry: 320-pixel row pitch, 320x240 sheet.
  localparam int unsigned SHEET_W_DEF     = 320;
  localparam int unsigned SHEET_DEPTH_DEF = 76800;

  // FRAME_TICKS <= 255 and FRAMES <= 8 fit these widths.
  localparam int unsigned TICK_W  = 8;
  localparam int unsigned FRAME_W = 3;

endpackage

// File: rtl/sprite_frame_ctr.sv
// Animation step counter: counts frame ticks and advances the walk frame
// index every FRAME_TICKS advances, wrapping FRAMES-1 -> 0.
// Ports: clk/rst, clr_i (synchronous clear, wins over advance),
//        adv_i (count one frame tick), frame_o (current frame index).
module sprite_frame_ctr
  import sprite_animator_pkg::*;
#(
  parameter int unsigned FRAMES      = 3,
  parameter int unsigned FRAME_TICKS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               adv_i,
  output logic [FRAME_W-1:0] frame_o
);

  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  always_comb begin
    tick_d  = tick_q;
    frame_d = frame_q;
    if (clr_i) begin
      tick_d  = '0;
      frame_d = '0;
    end else if (adv_i) begin
      if (tick_q == TICK_W'(FRAME_TICKS - 1)) begin
        tick_d  = '0;
        frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
      end else begin
        tick_d = tick_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      frame_q <= '0;
    end else begin
      tick_q  <= tick_d;
      frame_q <= frame_d;
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/sprite_animator.sv
// Walking-sprite renderer: OFF/IDLE/WALK animation FSM, per-video-frame
// shadow latching of position/direction, and a registered sheet lookup.
// Ports: clk/rst, en, frame_tick, h_cnt/v_cnt (scan), pos_x/pos_y, dir,
//        moving, hit -> pixel_addr, is_object (both 1 clk after the scan).
// Optional macro SPRITE_FLASH_EN adds a damage-flash blink driven by hit.
module sprite_animator
  import sprite_animator_pkg::*;
#(
  parameter int unsigned SPR_W       = 20,
  parameter int unsigned SPR_H       = 20,
  parameter int unsigned FRAMES      = 3,
  parameter int unsigned FRAME_TICKS = 8,
  parameter int unsigned SHEET_W     = SHEET_W_DEF,
  parameter int unsigned SHEET_DEPTH = SHEET_DEPTH_DEF,
  parameter int unsigned ORIGIN_X    = 0,
  parameter int unsigned ORIGIN_Y    = 20,
  parameter int unsigned SCALE_SHIFT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        frame_tick,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [8:0]  pos_x,
  input  logic [8:0]  pos_y,
  input  logic [1:0]  dir,
  input  logic        moving,
  input  logic        hit,
  output logic [16:0] pixel_addr,
  output logic        is_object
);

  state_e             state_q;
  logic [8:0]         px_q, py_q;
  dir_e               dir_q;
  logic               mv_q, mv_d;
  logic [FRAME_W-1:0] frame;
  logic               ctr_clr, ctr_adv;
  logic               flash_mask;

  // Value the shadow moving register holds after this edge; the FSM acts on it.
  assign mv_d = frame_tick ? moving : mv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_OFF;
    end else if (!en) begin
      state_q <= ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:  state_q <= ST_IDLE;
        ST_IDLE: if (frame_tick && mv_d)  state_q <= ST_WALK;
        ST_WALK: if (frame_tick && !mv_d) state_q <= ST_IDLE;
        default: state_q <= ST_OFF;
      endcase
    end
  end

  // Shadow copies change only at frame boundaries so a frame is drawn
  // from one consistent position/direction.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_q  <= '0;
      py_q  <= '0;
      dir_q <= DIR_UP;
      mv_q  <= 1'b0;
    end else if (frame_tick) begin
      px_q  <= pos_x;
      py_q  <= pos_y;
      dir_q <= dir_e'(dir);
      mv_q  <= moving;
    end
  end

  // Counters run only while staying in WALK; a direction change restarts
  // the walk cycle and wins over a simultaneous advance.
  assign ctr_adv = en && (state_q == ST_WALK) && frame_tick;
  assign ctr_clr = !en || (state_q != ST_WALK) ||
                   (frame_tick && (!mv_d || (dir_e'(dir) != dir_q)));

  sprite_frame_ctr #(
    .FRAMES      (FRAMES),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_frame_ctr (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (ctr_clr),
    .adv_i   (ctr_adv),
    .frame_o (frame)
  );

`ifdef SPRITE_FLASH_EN
  logic [3:0] flash_q;

  // hit wins over the frame-tick decrement; the count parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      flash_q <= '0;
    end else if (hit) begin
      flash_q <= 4'd15;
    end else if (frame_tick && (flash_q != 4'd0)) begin
      flash_q <= flash_q - 4'd1;
    end
  end

  assign flash_mask = (flash_q != 4'd0) && flash_q[1];
`else
  logic unused_hit;
  assign unused_hit = hit;
  assign flash_mask = 1'b0;
`endif

  logic [9:0]  x, y, sx, sy, lx, ly;
  logic        in_spr, vis;
  logic [31:0] addr_lin;
  logic [16:0] pixel_addr_d;

  assign x  = h_cnt >> SCALE_SHIFT;
  assign y  = v_cnt >> SCALE_SHIFT;
  assign sx = {1'b0, px_q};
  assign sy = {1'b0, py_q};

  // 10-bit compare: a sprite near the right/bottom edge is clipped, never wrapped.
  assign in_spr = (x >= sx) && (x < sx + 10'(SPR_W)) &&
                  (y >= sy) && (y < sy + 10'(SPR_H));
  assign lx = x - sx;
  assign ly = y - sy;

  assign addr_lin = (ORIGIN_Y + 32'(ly)) * SHEET_W + ORIGIN_X +
                    (32'(dir_q) * FRAMES + 32'(frame)) * SPR_W + 32'(lx);
  assign pixel_addr_d = 17'(addr_lin % SHEET_DEPTH);

  assign vis = en && (state_q != ST_OFF) && in_spr;

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_addr <= '0;
      is_object  <= 1'b0;
    end else begin
      pixel_addr <= vis ? pixel_addr_d : '0;
      is_object  <= vis && !flash_mask;
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Directed self-checking bench for sprite_animator (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Flash scenarios are compiled in only with SPRITE_FLASH_EN.
module tb_sprite_animator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        frame_tick = 1'b0;
  logic [9:0]  h_cnt = '0;
  logic [9:0]  v_cnt = '0;
  logic [8:0]  pos_x = '0;
  logic [8:0]  pos_y = '0;
  logic [1:0]  dir = '0;
  logic        moving = 1'b0;
  logic        hit = 1'b0;
  logic [16:0] pixel_addr;
  logic        is_object;

  int checks = 0;
  int failures = 0;

  sprite_animator dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .frame_tick (frame_tick),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .dir        (dir),
    .moving     (moving),
    .hit        (hit),
    .pixel_addr (pixel_addr),
    .is_object  (is_object)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame_tick pulse, then one more edge so the registered output
  // reflects the state the tick produced.
  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with the scan inside where a sprite would be.
    h_cnt = 10'd20;
    v_cnt = 10'd20;
    step();
    step();
    chk("rst_obj", 32'(is_object), 32'd0);
    chk("rst_addr", 32'(pixel_addr), 32'd0);
    rst = 1'b0;

    // Enable, start walking right at (10,10); scan at lx=0, ly=0.
    en = 1'b1;
    pos_x = 9'd10;
    pos_y = 9'd10;
    dir = 2'd1;
    moving = 1'b1;
    step();
    tick();
    chk("walk_start_obj", 32'(is_object), 32'd1);
    chk("walk_start_addr", 32'(pixel_addr), 32'd6460);

    // 8 ticks per step, frames 0,1,2,0,... ; frame f at dir 1 -> 6460+20f.
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk("walk_seq_addr", 32'(pixel_addr), 32'(6460 + 20 * ((t / 8) % 3)));
    end

    // Now at frame 2 with a fresh tick count: turn left on a tick.
    dir = 2'd2;
    tick();
    chk("dir_chg_addr", 32'(pixel_addr), 32'd6520);
    tick();
    chk("dir_hold_addr", 32'(pixel_addr), 32'd6520);
    h_cnt = 10'd30;
    v_cnt = 10'd26;
    step();
    chk("dir_offs_addr", 32'(pixel_addr), 32'd7485);

    // Mid-frame pos_x change must not show until the next tick.
    pos_x = 9'd500;
    h_cnt = 10'd1020;
    v_cnt = 10'd20;
    step();
    chk("tear_obj", 32'(is_object), 32'd0);
    tick();
    chk("edge510_obj", 32'(is_object), 32'd1);
    chk("edge510_addr", 32'(pixel_addr), 32'd6530);
    h_cnt = 10'd1022;
    step();
    chk("edge511_addr", 32'(pixel_addr), 32'd6531);
    h_cnt = 10'd8;
    step();
    chk("nowrap_obj", 32'(is_object), 32'd0);
    chk("nowrap_addr", 32'(pixel_addr), 32'd0);
    h_cnt = 10'd1000;
    v_cnt = 10'd58;
    step();
    chk("bottom_in_obj", 32'(is_object), 32'd1);
    chk("bottom_in_addr", 32'(pixel_addr), 32'd12600);
    v_cnt = 10'd60;
    step();
    chk("bottom_out_obj", 32'(is_object), 32'd0);

    // Back to (10,10); five more ticks complete the step to frame 1.
    pos_x = 9'd10;
    h_cnt = 10'd20;
    v_cnt = 10'd20;
    tick();
    for (int t = 0; t < 5; t++) tick();
    chk("dir2_f1_addr", 32'(pixel_addr), 32'd6540);

    // Drop enable during WALK, then re-enable.
    en = 1'b0;
    step();
    chk("en_off_obj", 32'(is_object), 32'd0);
    chk("en_off_addr", 32'(pixel_addr), 32'd0);
    en = 1'b1;
    step();
    chk("en_on_off_obj", 32'(is_object), 32'd0);
    step();
    chk("en_idle_obj", 32'(is_object), 32'd1);
    chk("en_idle_addr", 32'(pixel_addr), 32'd6520);

    // WALK -> IDLE returns to frame 0.
    tick();
    for (int t = 0; t < 8; t++) tick();
    chk("rewalk_f1_addr", 32'(pixel_addr), 32'd6540);
    moving = 1'b0;
    tick();
    chk("stop_idle_addr", 32'(pixel_addr), 32'd6520);

    // Reset mid-walk together with frame_tick.
    moving = 1'b1;
    tick();
    for (int t = 0; t < 8; t++) tick();
    chk("prerst_addr", 32'(pixel_addr), 32'd6540);
    rst = 1'b1;
    frame_tick = 1'b1;
    step();
    chk("midrst_obj", 32'(is_object), 32'd0);
    chk("midrst_addr", 32'(pixel_addr), 32'd0);
    rst = 1'b0;
    frame_tick = 1'b0;
    step();
    chk("postrst_off_obj", 32'(is_object), 32'd0);
    step();
    // Shadows cleared: sprite at (0,0), dir 0, frame 0, scan at x=10,y=10.
    chk("postrst_obj", 32'(is_object), 32'd1);
    chk("postrst_addr", 32'(pixel_addr), 32'd9610);

`ifdef SPRITE_FLASH_EN
    begin
      logic [3:0] fl;
      moving = 1'b0;
      dir = 2'd1;
      tick();
      chk("fl_pre_obj", 32'(is_object), 32'd1);
      chk("fl_pre_addr", 32'(pixel_addr), 32'd6460);
      hit = 1'b1;
      step();
      hit = 1'b0;
      step();
      chk("fl_hit_obj", 32'(is_object), 32'd0);
      for (int k = 1; k <= 16; k++) begin
        tick();
        fl = (k >= 15) ? 4'd0 : 4'(15 - k);
        chk("fl_blink_obj", 32'(is_object), 32'(!fl[1]));
      end
      hit = 1'b1;
      step();
      hit = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      chk("fl_cnt5_obj", 32'(is_object), 32'd1);
      hit = 1'b1;
      step();
      hit = 1'b0;
      step();
      chk("fl_reload_obj", 32'(is_object), 32'd0);
      tick();
      chk("fl_cnt14_obj", 32'(is_object), 32'd0);
      tick();
      chk("fl_cnt13_obj", 32'(is_object), 32'd1);
      hit = 1'b1;
      frame_tick = 1'b1;
      step();
      hit = 1'b0;
      frame_tick = 1'b0;
      step();
      chk("fl_hit_tick_obj", 32'(is_object), 32'd0);
      tick();
      chk("fl_hit_tick14_obj", 32'(is_object), 32'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_animator.md
SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 SHALL have parameter SPR_W, default 20, sprite width in source pixels.
REQ-002 SHALL have parameter SPR_H, default 20, sprite height in source pixels.
REQ-003 SHALL have parameter FRAMES, default 3, walk frames per direction (range 1..8).
REQ-004 SHALL have parameter FRAME_TICKS, default 8, frame_tick pulses per animation step (range 1..255).
REQ-005 SHALL have parameters SHEET_W (320), SHEET_DEPTH (76800), ORIGIN_X (0), ORIGIN_Y (20): sheet row pitch, address modulus, and sheet origin of the direction-0 frame-0 cell.
REQ-006 SHALL have parameter SCALE_SHIFT, default 1, screen-to-sprite scale: x = h_cnt>>SCALE_SHIFT, y = v_cnt>>SCALE_SHIFT.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have ports en (input, 1, draw enable for the current game stage) and frame_tick (input, 1, one-cycle pulse per video frame).
REQ-010 SHALL have ports h_cnt, v_cnt (input, 10 each, scan position) and pos_x, pos_y (input, 9 each, sprite top-left in scaled space).
REQ-011 SHALL have ports dir (input, 2; 0 up, 1 right, 2 left, 3 down) and moving (input, 1).
REQ-012 SHALL have port hit (input, 1, damage pulse); used only with SPRITE_FLASH_EN.
REQ-013 SHALL have ports pixel_addr (output, 17, sheet address) and is_object (output, 1, pixel belongs to sprite).

Function
REQ-014 SHALL run FSM OFF/IDLE/WALK: OFF when en=0; OFF->IDLE when en=1; IDLE->WALK when moving=1 on frame_tick; WALK->IDLE when moving=0 on frame_tick.
REQ-015 SHALL hold the tick counter and frame index at 0 in OFF and IDLE; IDLE displays frame 0.
REQ-016 In WALK, the tick counter SHALL increment on each frame_tick; on reaching FRAME_TICKS-1 it SHALL clear, and the frame index SHALL advance, wrapping FRAMES-1 -> 0.
REQ-017 SHALL latch pos_x, pos_y, dir and moving into shadow registers only on frame_tick; drawing SHALL use only the shadow values (no mid-frame tearing).
REQ-018 When the latched dir differs from the previous shadow dir, the frame index and tick counter SHALL clear to 0 in the same cycle, overriding any advance.
REQ-019 Hit test SHALL evaluate x >= sx && x < sx+SPR_W && y >= sy && y < sy+SPR_H at 10-bit width; a sprite extending past 511 is clipped and does not wrap.
REQ-020 pixel_addr SHALL be ((ORIGIN_Y+ly)*SHEET_W + ORIGIN_X + (dir*FRAMES+frame)*SPR_W + lx) mod SHEET_DEPTH, where lx = x-sx and ly = y-sy.
REQ-021 pixel_addr and is_object SHALL be registered with 1-clk latency from h_cnt/v_cnt; outside the sprite, or in OFF, the block SHALL output is_object=0 and pixel_addr=0.
REQ-022 When en falls during WALK, the block SHALL enter OFF on the next clk and clear all counters; it SHALL restart in IDLE at frame 0.

Reset
REQ-023 On rst=1 at clk edge: FSM=OFF; counters, shadow registers, pixel_addr, is_object and flash state SHALL be 0; rst SHALL override frame_tick and hit.

Configuration
REQ-024 Macro SPRITE_FLASH_EN SHALL, when defined, add a damage-flash feature with a 4-bit counter.
REQ-025 With SPRITE_FLASH_EN, hit SHALL load the flash counter with 15, and each frame_tick SHALL decrement it.
REQ-026 With SPRITE_FLASH_EN, while the flash counter is nonzero, is_object SHALL be forced 0 when counter bit 1 = 1.
REQ-027 With SPRITE_FLASH_EN, a hit during a flash SHALL reload 15; hit and frame_tick in the same cycle SHALL load 15.
REQ-028 Without SPRITE_FLASH_EN, hit SHALL be ignored, with no flash logic present.

Structure
REQ-029 Shared package SHALL hold the dir encoding, FSM state encodings, and default sheet geometry constants (SHEET_W, SHEET_DEPTH).
REQ-030 The tick and frame counters with their clear/advance logic SHALL form one sub-module, sprite_frame_ctr.

Verification
REQ-031 Defaults, moving=1, dir=1, 50 frame_ticks -> frame sequence 0,1,2,0,... with a change every 8 ticks; the bench SHALL check addr at lx=0, ly=0 for frame 1 = 20*320+80 = 6480.
REQ-032 While walking at frame 2, dir 1->2 on a tick -> frame=0 on the next cycle, with base address column 120.
REQ-033 pos_x=500, x=510 -> is_object=1; x=4 -> is_object=0 (no wrap); pos_x changed mid-frame -> no change until frame_tick.
REQ-034 en 1->0 during WALK -> is_object=0 one clk later; en re-asserted -> IDLE, frame 0.
REQ-035 With SPRITE_FLASH_EN: hit pulse, then 16 frame_ticks -> is_object masks in pattern of counter bit 1, and is 1 after count reaches 0; hit at count 5 -> reload 15.
REQ-036 rst asserted mid-walk together with frame_tick -> all outputs 0 at next clk; FSM=OFF.
